seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Iterative restoring divider: inverse of the combinational MUL_A_B cells.
//   - Accepts dividend A and divisor B over a valid/ready handshake.
//   - Produces quotient Q and remainder R, one quotient bit per clock.
//   - Sits in the operator library as the DIV implementation for synthesised expressions.
// PARAMETERS
//   WIDTH_A  4  dividend and quotient width (>=2)
//   WIDTH_B  4  divisor and remainder width (>=1)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        operands present on a/b
//   in_ready   out  1        block idle, can accept
//   a          in   WIDTH_A  dividend
//   b          in   WIDTH_B  divisor
//   out_valid  out  1        q/r/div_by_zero valid
//   out_ready  in   1        consumer takes result
//   q          out  WIDTH_A  quotient
//   r          out  WIDTH_B  remainder
//   div_by_zero out 1        b was zero for this result
// BEHAVIOUR
//   - Reset: sampled on a clk edge.
//     - Aborts any operation; an in-flight result is discarded.
//     - State = IDLE, in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     - IDLE: in_ready=1. On in_valid&in_ready, latch a/b.
//       - b!=0: go to RUN, bit counter = WIDTH_A-1.
//       - b==0: go to DONE directly.
//     - RUN: in_ready=0. Each edge shifts the next dividend bit (MSB first) into
//       a WIDTH_B+1 partial remainder.
//       - Trial-subtract b. If no borrow, keep the difference and shift in quotient bit 1.
//       - Otherwise restore and shift in 0.
//       - At counter==0, register q/r and go to DONE. Else decrement.
//     - DONE: out_valid=1, in_ready=0. q/r/div_by_zero are held stable while out_ready=0.
//       - On out_valid&out_ready, go to IDLE.
//       - The next accept is possible no earlier than the following edge.
//   - Latency: acceptance edge E0 -> out_valid visible after edge E0+WIDTH_A (b!=0),
//     or after E0+1 (b==0).
//   - Throughput: one op per WIDTH_A+2 cycles minimum.
//   - Divide by zero: q = all ones; r = a zero-extended/truncated to WIDTH_B; div_by_zero=1.
//   - Unsigned result: a == q*b + r, with r < b.
//   - in_valid in non-IDLE states is ignored (not accepted). Operand changes after
//     acceptance have no effect.
// CONFIGURATION
//   DIV_SIGNED_EN
//     - Defined:
//       - a and b are two's complement. Divide |a| by |b| using the same datapath.
//       - Negate q if sign(a)!=sign(b); negate r if a<0, on the RUN->DONE edge.
//       - Quotient truncates toward zero; r takes the sign of a.
//       - Overflow (a = most negative, b = -1): q = most negative, r = 0.
//       - b==0: q = all ones; r = a truncated/sign-extended to WIDTH_B; div_by_zero=1.
//       - Latency is unchanged.
//     - Undefined: unsigned only; no sign logic present.
// TESTING
//   1. WIDTH 4/4, a=13, b=3, out_ready=1 -> out_valid 4 cycles after accept; q=4, r=1,
//      div_by_zero=0; in_ready low during RUN/DONE.
//   2. a=9, b=0 -> out_valid 1 cycle after accept; q=4'hF, r=9, div_by_zero=1.
//   3. a=15, b=1 then a=2, b=7 back-to-back, out_ready held 0 for 5 cycles ->
//      - First result q=15, r=0 is held stable throughout the stall; second op not
//        accepted until after the handshake.
//      - Second result q=0, r=2.
//   4. rst asserted 2 cycles into RUN (a=12, b=5) ->
//      - Next cycle: out_valid=0, q=0, r=0, in_ready=1.
//      - A new op a=12, b=5 then gives q=2, r=2.
//   5. Exhaustive sweep all a, b (4/4) against the reference model a/b, a%b, with
//      random out_ready stalls -> zero mismatches.
//   6. DIV_SIGNED_EN: a=-7, b=2 -> q=4'b1101 (-3), r=4'b1111 (-1);
//      a=-8, b=-1 -> q=4'b1000, r=0.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module seq_divider #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-1:0] q,
  output logic [WIDTH_B-1:0] r,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH_A-1:0] dvd;
  logic [WIDTH_B-1:0] dvs;
  logic [WIDTH_B-1:0] rem;

  logic [WIDTH_A-1:0] a_mag;
  logic [WIDTH_B-1:0] b_mag;
  logic [WIDTH_A-1:0] q_fin;
  logic [WIDTH_B-1:0] r_fin;
  logic [WIDTH_B-1:0] dbz_r;

  // dvd doubles as the quotient register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  logic [WIDTH_B:0]   rem_sh;
  logic               q_bit;
  logic [WIDTH_B-1:0] rem_nxt;
  logic [WIDTH_A-1:0] dvd_nxt;

  assign rem_sh  = {rem, dvd[WIDTH_A-1]};
  assign q_bit   = (rem_sh >= {1'b0, dvs});
  // When the trial subtract succeeds the difference is below dvs, so WIDTH_B bits suffice.
  assign rem_nxt = q_bit ? (rem_sh[WIDTH_B-1:0] - dvs) : rem_sh[WIDTH_B-1:0];
  assign dvd_nxt = {dvd[WIDTH_A-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  localparam bit SIGN_EXT = 1'b1;
  logic neg_q;
  logic neg_r;
  assign a_mag = a[WIDTH_A-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH_B-1] ? (~b + 1'b1) : b;
  assign q_fin = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
  assign r_fin = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
`else
  localparam bit SIGN_EXT = 1'b0;
  assign a_mag = a;
  assign b_mag = b;
  assign q_fin = dvd_nxt;
  assign r_fin = rem_nxt;
`endif

  generate
    if (WIDTH_B > WIDTH_A) begin : g_dbz_ext
      assign dbz_r = {{(WIDTH_B-WIDTH_A){SIGN_EXT & a[WIDTH_A-1]}}, a};
    end else begin : g_dbz_trunc
      assign dbz_r = a[WIDTH_B-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (b == '0) begin
              state       <= DONE;
              q           <= '1;
              r           <= dbz_r;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= CW'(WIDTH_A - 1);
`ifdef DIV_SIGNED_EN
              neg_q <= a[WIDTH_A-1] ^ b[WIDTH_B-1];
              neg_r <= a[WIDTH_A-1];
`endif
            end
          end
        end
        RUN: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            q           <= q_fin;
            r           <= r_fin;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Divide-by-zero enters DONE with out_valid low; it rises one edge later.
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else if (!out_valid) begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (4/4): vector table, hand-written stall/reset sequences, full sweep.
module tb_seq_divider;

  localparam int WA = 4;
  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] q;
  logic [WB-1:0] r;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] vq;
    logic [3:0] vr;
    logic       vdz;
    int         vlat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic void ref_div(input logic [3:0] aa, input logic [3:0] bb,
                                  output logic [3:0] qq, output logic [3:0] rr,
                                  output logic dz);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    sa = aa[3] ? int'(aa) - 16 : int'(aa);
    sb = bb[3] ? int'(bb) - 16 : int'(bb);
    dz = (sb == 0);
    if (sb == 0) begin
      qq = 4'hF;
      rr = aa;
    end else if (sa == -8 && sb == -1) begin
      qq = 4'h8;
      rr = 4'h0;
    end else begin
      qq = 4'(sa / sb);
      rr = 4'(sa % sb);
    end
`else
    dz = (bb == 4'd0);
    if (bb == 4'd0) begin
      qq = 4'hF;
      rr = aa;
    end else begin
      qq = aa / bb;
      rr = aa % bb;
    end
`endif
  endfunction

  // Present operands once the divider is idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [3:0] aa, input logic [3:0] bb);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    check("out_valid_within_bound", out_valid, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[$];
    int         lat;
    bit         busy_ok;
    bit         stable;
    logic [3:0] cq, cr, eq, er;
    logic       edz;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 4});  // -7 / 2
    vecs.push_back('{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 4});  // overflow -8 / -1
    vecs.push_back('{4'hD, 4'h3, 4'hF, 4'h0, 1'b0, 4});  // -3 / 3
    vecs.push_back('{4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 4});  // 7 / -2
    vecs.push_back('{4'h5, 4'h3, 4'h1, 4'h2, 1'b0, 4});
    vecs.push_back('{4'h9, 4'h0, 4'hF, 4'h9, 1'b1, 1});  // -7 / 0
`else
    vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4});
    vecs.push_back('{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1});
    vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4});
    vecs.push_back('{4'd2,  4'd7,  4'd0,  4'd2, 1'b0, 4});
    vecs.push_back('{4'd12, 4'd5,  4'd2,  4'd2, 1'b0, 4});
    vecs.push_back('{4'd0,  4'd3,  4'd0,  4'd0, 1'b0, 4});
    vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4});
    vecs.push_back('{4'd7,  4'd15, 4'd0,  4'd7, 1'b0, 4});
    vecs.push_back('{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 1});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].va, vecs[i].vb);
      wait_result(lat, busy_ok);
      check($sformatf("vec%0d_q", i), q, vecs[i].vq);
      check($sformatf("vec%0d_r", i), r, vecs[i].vr);
      check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].vdz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].vlat);
      check($sformatf("vec%0d_in_ready_low_busy", i), busy_ok, 1);
      release_result();
      check($sformatf("vec%0d_out_valid_dropped", i), out_valid, 0);
    end

    // Stalled result with a second request already waiting on the input.
    start_op(4'd15, 4'd1);
    a        = 4'd2;
    b        = 4'd7;
    in_valid = 1'b1;
    wait_result(lat, busy_ok);
    cq = q;
    cr = r;
    check("stall_first_q", cq, 4'hF);
    check("stall_first_r", cr, 4'h0);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (q !== cq || r !== cr || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("stall_held_stable", stable, 1);
    check("stall_second_not_accepted", busy_ok, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_out_valid_after_hs", out_valid, 0);
    check("stall_idle_after_hs", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_second_accepted", in_ready, 0);
    wait_result(lat, busy_ok);
    check("stall_second_q", q, 4'd0);
    check("stall_second_r", r, 4'd2);
    check("stall_second_latency", lat, 4);
    release_result();

    // Reset in the middle of RUN discards the operation.
    start_op(4'd12, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_q", q, 0);
    check("midrun_rst_r", r, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    stable = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
    end
    check("midrun_rst_stays_idle", stable, 1);
    start_op(4'd12, 4'd5);
    wait_result(lat, busy_ok);
`ifdef DIV_SIGNED_EN
    check("after_rst_q", q, 4'h0);
    check("after_rst_r", r, 4'hC);
`else
    check("after_rst_q", q, 4'd2);
    check("after_rst_r", r, 4'd2);
`endif
    release_result();

    // Every operand pair, random result stalls and idle gaps.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        ref_div(4'(ai), 4'(bi), eq, er, edz);
        start_op(4'(ai), 4'(bi));
        wait_result(lat, busy_ok);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check($sformatf("sweep_%0d_%0d_q", ai, bi), q, eq);
        check($sformatf("sweep_%0d_%0d_r", ai, bi), r, er);
        check($sformatf("sweep_%0d_%0d_dbz", ai, bi), div_by_zero, edz);
        check($sformatf("sweep_%0d_%0d_latency", ai, bi), lat, (bi == 0) ? 1 : 4);
        release_result();
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
